// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: control codes,
// FSM state encoding and the per-op slice control decode.
package serial_alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
        logic       cin0;
        logic       slt;
        logic       arith;   // ADD/SUB: the only ops that report cout/overflow
    } slice_ctl_t;

    function automatic slice_ctl_t decode_ctl(input logic [3:0] code);
        slice_ctl_t c;
        c = '{legal: 1'b0, a_inv: 1'b0, b_inv: 1'b0, op: 2'b00,
              cin0: 1'b0, slt: 1'b0, arith: 1'b0};
        case (code)
            ALU_AND: begin c.legal = 1'b1; c.op = 2'b00; end
            ALU_OR:  begin c.legal = 1'b1; c.op = 2'b01; end
            ALU_ADD: begin c.legal = 1'b1; c.op = 2'b10; c.arith = 1'b1; end
            ALU_SUB: begin
                c.legal = 1'b1; c.b_inv = 1'b1; c.op = 2'b10;
                c.cin0 = 1'b1; c.arith = 1'b1;
            end
            ALU_SLT: begin
                c.legal = 1'b1; c.b_inv = 1'b1; c.op = 2'b10;
                c.cin0 = 1'b1; c.slt = 1'b1;
            end
            ALU_NOR: begin
                c.legal = 1'b1; c.a_inv = 1'b1; c.b_inv = 1'b1; c.op = 2'b00;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, full adder,
// and an AND/OR/SUM/LESS output mux (LESS is tied low in this design).
module serial_alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       a_inv,
    input  logic       b_inv,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       sum
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ a_inv;
    assign b_eff = b ^ b_inv;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        result = 1'b0;
        case (op)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: accepts an op, walks one slice over WIDTH
// cycles LSB first, then presents result and flags until consumed.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] src1_sr, src2_sr, res_sr;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] cnt;
    logic             carry, cin_msb, msb_sum;
    slice_ctl_t       ctl;
    logic             sl_res, sl_cout, sl_sum;
    logic [WIDTH-1:0] fin_result;

    assign ctl = decode_ctl(op_r);

    serial_alu_slice u_slice (
        .a      (src1_sr[0]),
        .b      (src2_sr[0]),
        .a_inv  (ctl.a_inv),
        .b_inv  (ctl.b_inv),
        .cin    (carry),
        .op     (ctl.op),
        .result (sl_res),
        .cout   (sl_cout),
        .sum    (sl_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN:    if (cnt == LAST) state_nxt = FINISH;
            FINISH: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In FINISH, carry holds the carry out of the MSB and cin_msb the carry into it.
    always_comb begin
        fin_result = res_sr;
        if (!ctl.legal)
            fin_result = '0;
        else if (ctl.slt)
            fin_result = {{(WIDTH-1){1'b0}}, msb_sum ^ (cin_msb ^ carry)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_sr  <= '0;
            src2_sr  <= '0;
            res_sr   <= '0;
            op_r     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            msb_sum  <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    src1_sr <= src1;
                    src2_sr <= src2;
                    op_r    <= alu_control;
                    cnt     <= '0;
                    carry   <= decode_ctl(alu_control).cin0;
                end
                RUN: begin
                    src1_sr <= {1'b0, src1_sr[WIDTH-1:1]};
                    src2_sr <= {1'b0, src2_sr[WIDTH-1:1]};
                    res_sr  <= {sl_res & ~ctl.slt, res_sr[WIDTH-1:1]};
                    carry   <= sl_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cin_msb <= carry;
                        msb_sum <= sl_sum;
                    end
                end
                FINISH: begin
                    result   <= fin_result;
                    zero     <= (fin_result == '0);
                    cout     <= ctl.arith & carry;
                    overflow <= ctl.arith & (cin_msb ^ carry);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl: vector table of ops with hand-computed
// results plus backpressure and mid-run reset sequences.
module tb_serial_alu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   alu_control = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, cout, overflow;

    int errors = 0;
    int checks = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accepts one op and waits for out_valid; returns cycles from accept edge.
    task automatic start_and_wait(input logic [3:0] ctl, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        src1 = a; src2 = b; alu_control = ctl; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = $urandom; src2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_and_wait(v.ctl, v.a, v.b, lat);
        check({v.name, " latency"}, 64'(lat), 64'(W + 1));
        check({v.name, " result"}, 64'(result), 64'(v.res));
        check({v.name, " zero"}, 64'(zero), 64'(v.z));
        check({v.name, " cout"}, 64'(cout), 64'(v.c));
        check({v.name, " overflow"}, 64'(overflow), 64'(v.v));
        consume();
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        vecs[0]  = '{"add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"sub_eq",   4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"slt_ovf",  4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"nor",      4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"illegal",  4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"or",       4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{"sub_neg",  4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"slt_gt",   4'b0111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{"slt_min",  4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};

        // reset state
        #12;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst flags", {61'd0, zero, cout, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure: DONE held 5 cycles while in_valid is asserted
        start_and_wait(4'b0010, 32'h00001000, 32'h00000234, lat);
        held = result;
        check("bp result", 64'(held), 64'h1234);
        src1 = 32'hDEAD0000; src2 = 32'h0000BEEF; alu_control = 4'b0001; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp hold", 64'(result), 64'(held));
        end
        in_valid = 1'b0;
        consume();
        check("bp idle in_ready", 64'(in_ready), 64'd1);
        check("bp idle out_valid", 64'(out_valid), 64'd0);
        check("bp idle hold", 64'(result), 64'(held));

        // out_ready held high outside DONE; result must not move during RUN
        out_ready = 1'b1;
        src1 = 32'h00000010; src2 = 32'h00000001; alu_control = 4'b0110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("run hold", 64'(result), 64'(held));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("rdy_hi valid", 64'(out_valid), 64'd1);
        check("rdy_hi result", 64'(result), 64'h0000000F);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rdy_hi back idle", 64'(in_ready), 64'd1);

        // reset while bit 10 is being processed
        src1 = 32'h0000FFFF; src2 = 32'h00000001; alu_control = 4'b0010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", 64'(out_valid), 64'd0);
        check("mid_rst result", 64'(result), 64'd0);
        check("mid_rst flags", {61'd0, zero, cout, overflow}, 64'd0);
        check("mid_rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_and_wait(4'b0010, 32'd3, 32'd4, lat);
        check("post_rst latency", 64'(lat), 64'(W + 1));
        check("post_rst result", 64'(result), 64'd7);
        check("post_rst zero", 64'(zero), 64'd0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
